// File: rtl/seq_serializer.sv
// Parallel-to-serial word shifter with a valid/ready load port.
// Loads a word into a shift register and emits it one bit per clock.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dout_n;
    logic             valid_n;
    logic             last;
    logic             accept;

    assign last       = (state == SHIFT) && (cnt == '0);
    assign load_ready = (state == IDLE) || last;
    assign frame_done = last;
    assign accept     = load_valid && load_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            dout       <= dout_n;
            dout_valid <= valid_n;
        end
    end

    // sreg shifts so the next bit always sits next to the one already on dout
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        dout_n  = 1'b0;
        valid_n = 1'b0;
        if (accept) begin
            state_n = SHIFT;
            sreg_n  = data_in;
            cnt_n   = CW'(WIDTH - 1);
            dout_n  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            valid_n = 1'b1;
        end else if (state == SHIFT && cnt != '0) begin
            sreg_n  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            cnt_n   = cnt - 1'b1;
            dout_n  = MSB_FIRST ? sreg[WIDTH-2] : sreg[1];
            valid_n = 1'b1;
        end else if (last) begin
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: vector table plus scoreboard,
// with hand-written sequences for ignored loads, async reset and LSB-first.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       load_valid;
    logic       load_ready;
    logic       dout;
    logic       dout_valid;
    logic       frame_done;

    logic [3:0] d4;
    logic       lv4;
    logic       lr4;
    logic       do4;
    logic       dv4;
    logic       fd4;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .data_in(data_in),
        .load_valid(load_valid), .load_ready(load_ready),
        .dout(dout), .dout_valid(dout_valid), .frame_done(frame_done)
    );

    seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .reset(reset), .data_in(d4),
        .load_valid(lv4), .load_ready(lr4),
        .dout(do4), .dout_valid(dv4), .frame_done(fd4)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp;
        int         gap;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    bit         q[$];
    int         mrem   = 0;
    bit         mon_en = 1'b0;
    logic [7:0] cur_exp = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: remaining bit count and queue of expected bits
    always @(posedge clk) begin
        if (mon_en) begin
            if (!reset) begin
                mrem = 0;
                q.delete();
            end else if (load_valid && mrem <= 1) begin
                for (int i = 7; i >= 0; i--) q.push_back(cur_exp[i]);
                mrem = 8;
            end else if (mrem > 0) begin
                mrem--;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("load_ready", load_ready, mrem <= 1);
            chk("dout_valid", dout_valid, mrem > 0);
            if (mrem > 0) begin
                if (q.size() == 0) begin
                    chk("queue_empty", 1, 0);
                end else begin
                    chk("dout", dout, q.pop_front());
                end
                chk("frame_done", frame_done, mrem == 1);
            end else begin
                chk("dout_idle", dout, 0);
                chk("frame_done_idle", frame_done, 0);
            end
        end
    end

    task automatic send(logic [7:0] d, logic [7:0] e, int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        load_valid = 1'b1;
        data_in    = d;
        cur_exp    = e;
        n = 0;
        while (!load_ready && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 40) chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mrem != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 60) chk("idle_timeout", 1, 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h55, 8'h55, 0};
        vecs[1] = '{8'hA5, 8'hA5, 2};
        vecs[2] = '{8'h3C, 8'h3C, 0};
        vecs[3] = '{8'h00, 8'h00, 1};
        vecs[4] = '{8'hFF, 8'hFF, 0};
        vecs[5] = '{8'h81, 8'h81, 5};
        vecs[6] = '{8'h01, 8'h01, 0};

        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        lv4        = 1'b0;
        d4         = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_ready", load_ready, 1);
        chk("rst_ready4", lr4, 1);
        chk("rst_valid4", dv4, 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) send(vecs[i].data, vecs[i].exp, vecs[i].gap);
        wait_idle();

        // load attempt during bit 3 must be ignored
        send(8'hC3, 8'hC3, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = 8'hFF;
        chk("busy_ready", load_ready, 0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_idle();

        // async reset mid-word, then accept on the first edge after release
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        send(8'hF0, 8'hF0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3;
        reset = 1'b0;
        mrem  = 0;
        q.delete();
        #1;
        chk("abort_dout", dout, 0);
        chk("abort_valid", dout_valid, 0);
        chk("abort_fdone", frame_done, 0);
        chk("abort_ready", load_ready, 1);
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        data_in    = 8'h96;
        cur_exp    = 8'h96;
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        wait_idle();

        // LSB-first, 4-bit instance
        lv4 = 1'b1;
        d4  = 4'b0011;
        chk("w4_ready", lr4, 1);
        @(posedge clk);
        #1;
        lv4 = 1'b0;
        d4  = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w4_dout", do4, (i < 2) ? 1 : 0);
            chk("w4_valid", dv4, 1);
            chk("w4_fdone", fd4, i == 3);
        end
        @(negedge clk);
        chk("w4_end_valid", dv4, 0);
        chk("w4_end_dout", do4, 0);
        @(posedge clk);
        #1;

        wait_idle();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; all registers clear immediately when reset=0, independent of clk.
REQ-005 data_in  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-006 load_valid  input  1  upstream requests a word load.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 dout  output  1  serial bit stream, one bit per clk; drives the din input of the downstream sequence detector.
REQ-009 dout_valid  output  1  dout carries a word bit this cycle.
REQ-010 frame_done  output  1  one-cycle pulse while the last bit of a word is on dout.

Function
REQ-011 States: IDLE and SHIFT; 2-bit-or-smaller encoding, any encoding.
REQ-012 Internal registers: shift register sreg[WIDTH-1:0]; down-counter cnt of width clog2(WIDTH).
REQ-013 load_ready = 1 in IDLE, or in SHIFT when cnt==0 (last-bit cycle); else 0; combinational from registered state only, no path from load_valid.
REQ-014 Accept = load_valid && load_ready at a rising edge.
REQ-015 On accept: sreg <= data_in; dout <= first bit per MSB_FIRST; dout_valid <= 1; cnt <= WIDTH-1; state <= SHIFT.
REQ-016 In SHIFT with cnt>0 at a rising edge: dout <= next bit in order; cnt <= cnt-1; dout_valid stays 1.
REQ-017 Each word bit is on dout for exactly one clk cycle; word latency is 1 cycle from accept edge to first bit; a word occupies exactly WIDTH consecutive cycles.
REQ-018 frame_done = 1 exactly when state==SHIFT and cnt==0; else 0.
REQ-019 Last-bit cycle with accept (back-to-back): next word's first bit appears on the following cycle; no gap; dout_valid stays 1.
REQ-020 Last-bit cycle without accept: next edge sets state <= IDLE, dout <= 0, dout_valid <= 0.
REQ-021 In IDLE without accept: dout = 0, dout_valid = 0, sreg and cnt hold.
REQ-022 load_valid while load_ready=0: ignored; data_in not sampled; current word continues unaltered; upstream is expected to hold load_valid until accepted.
REQ-023 Changes to data_in after accept do not affect the word being shifted.
REQ-024 No bit of a word is dropped, duplicated or reordered under any load_valid pattern.

Reset
REQ-025 While reset=0: state=IDLE, sreg=0, cnt=0, dout=0, dout_valid=0, frame_done=0, load_ready=1.
REQ-026 Reset asserted mid-word aborts the word immediately; no remaining bits are emitted after release.
REQ-027 First edge after reset release behaves as IDLE; an accept on that edge is honoured.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, load 8'b0101_0101 from IDLE -> dout = 0,1,0,1,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; dout_valid=1 for those 8; frame_done=1 on the 8th only; then dout=0, dout_valid=0.
REQ-029 Back-to-back: load 8'hA5, hold load_valid with 8'h3C ready at the last-bit cycle -> 16 consecutive valid bits 1010_0101_0011_1100; exactly two frame_done pulses, at cycles 8 and 16.
REQ-030 Pulse load_valid with 8'hFF during bit 3 of a word in progress -> ignored, load_ready=0, original word completes intact, no 8'hFF bits emitted.
REQ-031 MSB_FIRST=0, WIDTH=4, load 4'b0011 -> dout = 1,1,0,0; frame_done on the 4th bit.
REQ-032 Assert reset=0 asynchronously between edges during bit 4 -> dout, dout_valid and frame_done go 0 without waiting for clk; after release, load_ready=1 and no stale bits appear.
REQ-033 Chain into the sequence detector, load 8'b0101_0000 -> detector's z asserts once, aligned to the 4th serialized bit per the detector's own timing.
